sr_cmd_conditioner: RTL and testbench
=====================================

Name: sr_cmd_conditioner

Overview:
- Upstream stage of the SR flip-flop.
- Takes two raw, asynchronous request lines (set and reset, e.g. pushbuttons or off-domain strobes) and synchronizes and debounces each one.
- Converts each debounced rising edge into a single-cycle S or R pulse.
- Guarantees S and R are never asserted together, and enforces a minimum spacing between commands.
- S and R outputs drive the flip-flop's S/R inputs directly.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per input (min 2).
- DB_CYCLES, 16: consecutive stable cycles required before the debounced level changes (min 1).
- HOLDOFF, 4: cycles in HOLD after each issued command (min 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- set_raw  input  1  raw set request; asynchronous and may bounce.
- rst_raw  input  1  raw reset request; asynchronous and may bounce.
- S  output  1  set pulse to the flip-flop; registered, one cycle wide.
- R  output  1  reset pulse to the flip-flop; registered, one cycle wide.
- busy  output  1  high while in ISSUE or HOLD.
- conflict  output  1  one-cycle pulse when set and reset are pending together in IDLE.
- set_db  output  1  debounced set level (observability).
- rst_db  output  1  debounced reset level (observability).

Behaviour:
- Reset, asynchronous with rst_n=0:
  - S, R, busy, conflict, set_db, rst_db = 0.
  - Sync chains, debounce counters and pending flags cleared; FSM = IDLE.
  - Inputs held high through reset release count as rising edges and issue after the normal latency.
- Synchronizer: SYNC_STAGES-flop chain per channel; no logic between the flops.
- Debounce, per channel:
  - Counter width $clog2(DB_CYCLES+1).
  - While the sync output differs from the debounced level, the counter increments. When it reaches DB_CYCLES, the debounced level toggles and the counter clears.
  - Any cycle where the sync output equals the debounced level clears the counter, so glitches shorter than DB_CYCLES are rejected.
- Edge detect: a debounced 0->1 transition sets that channel's pending flag. Falling edges are ignored.
- Pending flags:
  - One deep per channel; repeated edges while already pending merge into the one request.
  - A flag clears only when its command issues or is discarded by arbitration.
- FSM states: IDLE, ISSUE_S, ISSUE_R, HOLD.
  - IDLE, only reset pending -> ISSUE_R.
  - IDLE, only set pending -> ISSUE_S.
  - IDLE, both pending -> ISSUE_R. The set pending flag is discarded and conflict pulses for exactly one cycle. Reset wins.
  - IDLE, nothing pending -> stay in IDLE.
  - ISSUE_S: S=1 for exactly this cycle; clear set pending -> HOLD.
  - ISSUE_R: R=1 for exactly this cycle; clear reset pending -> HOLD.
  - HOLD: HOLDOFF cycles, then IDLE. Edges arriving in HOLD set pending flags and are serviced from IDLE afterwards.
- Command spacing: consecutive commands are separated by at least HOLDOFF+1 cycles. The same command may repeat.
- Invariant: S&R == 0 in every cycle.
- busy = 1 in ISSUE_* and HOLD; 0 in IDLE.
- Latency from the first clk edge sampling a new stable raw level to S/R high, in IDLE with nothing pending: SYNC_STAGES + DB_CYCLES + 2 cycles (20 at defaults).
- Reset mid-operation: S/R drop immediately (asynchronously) and all pending state is lost.

Test Plan:
- Clean set_raw 0->1 held 40 cycles, defaults -> set_db rises, S=1 for exactly one cycle 20 cycles after sampling, R stays 0, busy high for 5 cycles starting with the S cycle.
- Bounce: set_raw toggled every 5 cycles for 60 cycles, then held low -> set_db never rises, S never asserts.
- set_raw and rst_raw rise on the same cycle -> R pulses once, S never asserts, conflict pulses once on the issue-decision cycle.
- set_raw rises, then rst_raw's debounced edge lands 2 cycles after the S pulse (inside HOLD) -> R pulses exactly HOLDOFF+1=5 cycles after S; S&R never both 1.
- set_raw held high across rst_n deassertion -> after release S pulses once at the standard latency; rst_n asserted in the cycle S=1 -> S drops to 0 immediately and no further pulse occurs after release (input then low).
- Random stimulus, 10k cycles -> S&R always 0; every S/R pulse exactly one cycle wide; pulses spaced at least 5 cycles apart.

Source files
------------

// File: rtl/sr_cmd_conditioner.sv
// Request conditioner ahead of the SR flip-flop: synchronizes and debounces raw set/reset
// lines, turns debounced rising edges into spaced, mutually exclusive one-cycle S/R pulses.
module sr_cmd_conditioner #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 16,
   parameter int unsigned HOLDOFF     = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_raw,
   input  logic rst_raw,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict,
   output logic set_db,
   output logic rst_db
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam int unsigned HW = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE_S,
      ISSUE_R,
      HOLD
   } state_t;

   // Channel index 0 carries set, index 1 carries reset.
   logic [1:0] raw_w;
   logic [1:0] db_w;
   logic [1:0] rise_w;
   logic [1:0] db_prev_q;
   logic [1:0] pend_q, pend_d;
   logic [1:0] clr_w;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          s_q, s_d;
   logic          r_q, r_d;
   logic          busy_q, busy_d;
   logic          conflict_q, conflict_d;
   logic          arb_w;

   assign raw_w = {rst_raw, set_raw};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   db_q, db_d;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_w[ch]};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
         end
      end

      // The counter holds DB_CYCLES for one cycle; the level flips on the following edge.
      always_comb begin
         cnt_d = cnt_q;
         db_d  = db_q;
         if (cnt_q == CW'(DB_CYCLES)) begin
            db_d  = ~db_q;
            cnt_d = '0;
         end else if (sync_q[SYNC_STAGES-1] != db_q) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = '0;
         end
      end

      assign db_w[ch] = db_q;
   end

   assign rise_w = db_w & ~db_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_prev_q  <= '0;
         pend_q     <= '0;
         state_q    <= IDLE;
         hold_q     <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         db_prev_q  <= db_w;
         pend_q     <= pend_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         s_q        <= s_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   // The last HOLD cycle arbitrates like IDLE so commands can follow HOLDOFF+1 cycles apart.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      clr_w      = '0;
      conflict_d = 1'b0;
      arb_w      = 1'b0;
      case (state_q)
         IDLE: arb_w = 1'b1;
         ISSUE_S: begin
            clr_w[0] = 1'b1;
            state_d  = HOLD;
            hold_d   = HW'(HOLDOFF - 1);
         end
         ISSUE_R: begin
            clr_w[1] = 1'b1;
            state_d  = HOLD;
            hold_d   = HW'(HOLDOFF - 1);
         end
         HOLD: begin
            if (hold_q == '0) begin
               state_d = IDLE;
               arb_w   = 1'b1;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (arb_w) begin
         if (pend_q[1]) begin
            state_d = ISSUE_R;
            if (pend_q[0]) begin
               conflict_d = 1'b1;
               clr_w[0]   = 1'b1;
            end
         end else if (pend_q[0]) begin
            state_d = ISSUE_S;
         end
      end
      pend_d = rise_w | (pend_q & ~clr_w);
      s_d    = (state_d == ISSUE_S);
      r_d    = (state_d == ISSUE_R);
      busy_d = (state_d != IDLE);
   end

   assign S        = s_q;
   assign R        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;
   assign set_db   = db_w[0];
   assign rst_db   = db_w[1];

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: time-based reference model checked every cycle,
// directed scenarios with literal latency/count expectations, then random bouncing inputs.
module tb_sr_cmd_conditioner;

   localparam int SYNC = 2;
   localparam int DB   = 16;
   localparam int HO   = 4;
   localparam int LAT  = SYNC + DB + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_raw = 1'b0;
   logic rst_raw = 1'b0;
   logic S, R, busy, conflict, set_db, rst_db;

   always #5 clk = ~clk;

   sr_cmd_conditioner #(
      .SYNC_STAGES(SYNC),
      .DB_CYCLES  (DB),
      .HOLDOFF    (HO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_raw (set_raw),
      .rst_raw (rst_raw),
      .S       (S),
      .R       (R),
      .busy    (busy),
      .conflict(conflict),
      .set_db  (set_db),
      .rst_db  (rst_db)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0b expected %0b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: delay line, run-length debounce, pending flags and a
   // "cycles since last command" rule for arbitration and busy.
   bit [SYNC-1:0] msh [2];
   bit   mdb [2];
   bit   mdb_prev [2];
   int   mrun [2];
   bit   mpend [2];
   bit   have_last;
   int   last_cmd;
   bit   eS, eR, eBusy, eConf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            msh[ch] = '0; mdb[ch] = 0; mdb_prev[ch] = 0; mrun[ch] = 0; mpend[ch] = 0;
         end
         have_last = 0; last_cmd = 0;
         eS = 0; eR = 0; eBusy = 0; eConf = 0;
      end else begin
         int  c;
         bit  ok, nS, nR, nC;
         bit  raw [2];
         bit  rise [2];
         bit  clr [2];
         c = cyc + 1;
         raw[0] = set_raw; raw[1] = rst_raw;
         for (int ch = 0; ch < 2; ch++) rise[ch] = mdb[ch] & ~mdb_prev[ch];
         clr[0] = eS; clr[1] = eR;
         ok = !have_last || (c - last_cmd >= HO + 1);
         nS = 0; nR = 0; nC = 0;
         if (ok && mpend[1]) begin
            nR = 1;
            if (mpend[0]) begin nC = 1; clr[0] = 1; end
         end else if (ok && mpend[0]) begin
            nS = 1;
         end
         if (nS || nR) begin have_last = 1; last_cmd = c; end
         eBusy = have_last && (c - last_cmd <= HO);
         eS = nS; eR = nR; eConf = nC;
         for (int ch = 0; ch < 2; ch++) begin
            mpend[ch] = rise[ch] | (mpend[ch] & ~clr[ch]);
            mdb_prev[ch] = mdb[ch];
            if (mrun[ch] == DB) begin
               mdb[ch] = ~mdb[ch]; mrun[ch] = 0;
            end else if (msh[ch][SYNC-1] != mdb[ch]) begin
               mrun[ch]++;
            end else begin
               mrun[ch] = 0;
            end
            msh[ch] = {msh[ch][SYNC-2:0], raw[ch]};
         end
      end
   end

   bit pS = 0, pR = 0;
   int last_p = -1000;

   always @(negedge clk) begin
      check("S", S, eS);
      check("R", R, eR);
      check("busy", busy, eBusy);
      check("conflict", conflict, eConf);
      check("set_db", set_db, mdb[0]);
      check("rst_db", rst_db, mdb[1]);
      check("S_and_R", S & R, 1'b0);
      check("S_width", S & pS, 1'b0);
      check("R_width", R & pR, 1'b0);
      if (!rst_n) begin
         last_p = -1000;
      end else if (S || R) begin
         check("pulse_spacing", (cyc - last_p) >= HO + 1, 1'b1);
         last_p = cyc;
      end
      pS = S; pR = R;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic observe(input int n, output int s_at, output int r_at, output int c_at,
                          output int s_n, output int r_n, output int c_n, output int b_n,
                          output bit sdb_seen);
      s_at = -1; r_at = -1; c_at = -1;
      s_n = 0; r_n = 0; c_n = 0; b_n = 0; sdb_seen = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (S) begin s_n++; if (s_at < 0) s_at = cyc; end
         if (R) begin r_n++; if (r_at < 0) r_at = cyc; end
         if (conflict) begin c_n++; if (c_at < 0) c_at = cyc; end
         if (busy) b_n++;
         if (set_db) sdb_seen = 1;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_S"}, S, 1'b0);
      check({tag, "_R"}, R, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_conflict"}, conflict, 1'b0);
      check({tag, "_set_db"}, set_db, 1'b0);
      check({tag, "_rst_db"}, rst_db, 1'b0);
   endtask

   initial begin
      int s_at, r_at, c_at, s_n, r_n, c_n, b_n, t0;
      bit sdb;
      int hl [2];

      tick(3);
      check_reset_outs("rst0");
      rst_n = 1'b1;
      tick(5);

      // Clean set request.
      set_raw = 1'b1;
      t0 = cyc + 1;
      observe(40, s_at, r_at, c_at, s_n, r_n, c_n, b_n, sdb);
      check_int("clean_lat", s_at - t0, LAT);
      check_int("clean_S_count", s_n, 1);
      check_int("clean_R_count", r_n, 0);
      check_int("clean_busy_cycles", b_n, HO + 1);
      check_int("clean_set_db_seen", int'(sdb), 1);
      set_raw = 1'b0;
      tick(30);

      // Bouncing set line must be rejected.
      begin
         int ts, tb_n;
         bit any_db;
         ts = 0; any_db = 0;
         for (int k = 0; k < 12; k++) begin
            set_raw = ~set_raw;
            observe(5, s_at, r_at, c_at, s_n, r_n, c_n, tb_n, sdb);
            ts += s_n; any_db |= sdb;
         end
         set_raw = 1'b0;
         observe(30, s_at, r_at, c_at, s_n, r_n, c_n, tb_n, sdb);
         ts += s_n; any_db |= sdb;
         check_int("bounce_S_count", ts, 0);
         check_int("bounce_set_db_seen", int'(any_db), 0);
      end

      // Simultaneous set and reset: reset wins.
      set_raw = 1'b1; rst_raw = 1'b1;
      t0 = cyc + 1;
      observe(40, s_at, r_at, c_at, s_n, r_n, c_n, b_n, sdb);
      check_int("both_R_count", r_n, 1);
      check_int("both_S_count", s_n, 0);
      check_int("both_conflict_count", c_n, 1);
      check_int("both_conflict_at_R", c_at, r_at);
      check_int("both_lat", r_at - t0, LAT);
      set_raw = 1'b0; rst_raw = 1'b0;
      tick(30);

      // Reset request landing inside HOLD after a set.
      set_raw = 1'b1;
      t0 = cyc + 1;
      tick(4);
      rst_raw = 1'b1;
      observe(40, s_at, r_at, c_at, s_n, r_n, c_n, b_n, sdb);
      check_int("hold_S_lat", s_at - t0, LAT);
      check_int("hold_R_after_S", r_at - s_at, HO + 1);
      check_int("hold_S_count", s_n, 1);
      check_int("hold_R_count", r_n, 1);
      check_int("hold_conflict_count", c_n, 0);
      set_raw = 1'b0; rst_raw = 1'b0;
      tick(30);

      // Set held across reset release, then reset during the S cycle.
      rst_n = 1'b0;
      set_raw = 1'b1;
      tick(3);
      check_reset_outs("rst1");
      rst_n = 1'b1;
      t0 = cyc + 1;
      s_at = -1;
      for (int i = 0; i < 40 && s_at < 0; i++) begin
         tick(1);
         if (S) s_at = cyc;
      end
      check_int("rel_lat", s_at - t0, LAT);
      rst_n = 1'b0;
      set_raw = 1'b0;
      #1;
      check("S_async_drop", S, 1'b0);
      check("busy_async_drop", busy, 1'b0);
      tick(2);
      rst_n = 1'b1;
      observe(40, s_at, r_at, c_at, s_n, r_n, c_n, b_n, sdb);
      check_int("post_rst_S_count", s_n, 0);
      check_int("post_rst_R_count", r_n, 0);

      // Random bouncing inputs with a mix of glitches and long holds.
      hl[0] = 0; hl[1] = 0;
      for (int i = 0; i < 10000; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (hl[ch] == 0) begin
               bit v;
               v = 1'($urandom_range(0, 1));
               if (ch == 0) set_raw = v; else rst_raw = v;
               hl[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                    : int'($urandom_range(15, 60));
            end
            hl[ch]--;
         end
         tick(1);
      end
      set_raw = 1'b0; rst_raw = 1'b0;
      tick(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
